// File: rtl/temp_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : temp_defs (package)
// Description : Shared encodings for the temperature monitor path: the
//               monitor's 2-bit state codes, the alarm_ctrl FSM states and
//               the alarm level codes driven on alarm_level.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package temp_defs;

    // Monitor output encodings
    localparam logic [1:0] STATE_NORMAL     = 2'd0;
    localparam logic [1:0] STATE_BORDERLINE = 2'd1;
    localparam logic [1:0] STATE_ATTENTION  = 2'd2;
    localparam logic [1:0] STATE_EMERGENCY  = 2'd3;

    // alarm_ctrl sequencer states
    typedef enum logic [1:0] {
        AC_IDLE  = 2'd0,
        AC_ATTN  = 2'd1,
        AC_EMERG = 2'd2,
        AC_SIL   = 2'd3
    } ac_state_e;

    // alarm_level encodings (value 1 is never driven)
    localparam logic [1:0] LEVEL_NONE  = 2'd0;
    localparam logic [1:0] LEVEL_ATTN  = 2'd2;
    localparam logic [1:0] LEVEL_EMERG = 2'd3;

endpackage
`default_nettype wire

// File: rtl/alarm_ctrl_blink_gen.sv
`default_nettype none
// ============================================================================
// Module      : blink_gen
// Description : Square-wave phase generator. The phase toggles every HALF
//               cycles; restart forces phase high and realigns the counter so
//               the first cycle after restart is always in the lit phase.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               restart - synchronous restart (phase -> 1, counter -> 0)
//               phase   - current blink phase
// Revision    : 1.0 - initial release
// ============================================================================
module blink_gen #(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic phase
);

    localparam int                CNT_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == C_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ctrl
// Description : Latched, acknowledgeable alarm sequencer driven by the
//               temperature monitor state. Adds clear hysteresis, operator
//               silence on an ack rising edge, and slow/fast blink patterns.
// Ports       : clk         - system clock
//               rst_n       - asynchronous active-low reset
//               state       - monitor state (0 normal .. 3 emergency)
//               ack         - debounced acknowledge level (rising edge used)
//               alarm_level - 0 none, 2 attention, 3 emergency (registered)
//               silenced    - high while the alarm is silenced (registered)
//               leds        - LED bank drive (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_ctrl
    import temp_defs::*;
#(
    parameter int LED_W       = 10,
    parameter int SEC_CYCLES  = 50_000_000,
    parameter int SLOW_HALF   = 25_000_000,
    parameter int FAST_HALF   = 6_250_000,
    parameter int SILENCE_SEC = 10,
    parameter int CLEAR_SEC   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       state,
    input  logic             ack,
    output logic [1:0]       alarm_level,
    output logic             silenced,
    output logic [LED_W-1:0] leds
);

    localparam longint C_SIL_CYC = longint'(SEC_CYCLES) * longint'(SILENCE_SEC);
    localparam longint C_CLR_CYC = longint'(SEC_CYCLES) * longint'(CLEAR_SEC);
    localparam longint C_MAX_CYC = (C_SIL_CYC > C_CLR_CYC) ? C_SIL_CYC : C_CLR_CYC;
    localparam int     CNT_W     = $clog2(C_MAX_CYC + 1);

    localparam logic [CNT_W-1:0] C_SEC_LAST = CNT_W'(SEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CLR_LAST = CNT_W'(CLEAR_SEC - 1);
    localparam logic [CNT_W-1:0] C_SIL_LAST = CNT_W'(C_SIL_CYC - 1);

    ac_state_e        fsm_q, fsm_d;
    ac_state_e        sil_from_q, sil_from_d;
    logic             ack_q;
    logic [CNT_W-1:0] clr_cyc_q, clr_cyc_d;
    logic [CNT_W-1:0] clr_sec_q, clr_sec_d;
    logic [CNT_W-1:0] sil_cnt_q, sil_cnt_d;
    logic [1:0]       alarm_level_q, alarm_level_d;
    logic             silenced_q, silenced_d;
    logic [LED_W-1:0] leds_q, leds_d;

    logic ack_rise;
    logic clr_cond;
    logic clr_done;
    logic sil_done;
    logic slow_restart, fast_restart;
    logic slow_phase, fast_phase;

    assign ack_rise = ack & ~ack_q;

    // ------------------------------------------------------------------
    // Next-state, clear counter and silence timer
    // ------------------------------------------------------------------
    always_comb begin
        fsm_d      = fsm_q;
        sil_from_d = sil_from_q;
        clr_cond   = 1'b0;

        case (fsm_q)
            AC_ATTN:  clr_cond = (state == STATE_NORMAL) || (state == STATE_BORDERLINE);
            AC_EMERG: clr_cond = (state != STATE_EMERGENCY);
            default:  clr_cond = 1'b0;
        endcase

        // Expires on the last cycle of the final qualifying second
        clr_done = clr_cond && (clr_cyc_q == C_SEC_LAST) && (clr_sec_q == C_CLR_LAST);
        sil_done = (sil_cnt_q == C_SIL_LAST);

        case (fsm_q)
            AC_IDLE: begin
                if (state == STATE_EMERGENCY)      fsm_d = AC_EMERG;
                else if (state == STATE_ATTENTION) fsm_d = AC_ATTN;
            end
            AC_ATTN: begin
                // Escalation beats ack, ack beats clear expiry
                if (state == STATE_EMERGENCY) begin
                    fsm_d = AC_EMERG;
                end else if (ack_rise) begin
                    fsm_d      = AC_SIL;
                    sil_from_d = AC_ATTN;
                end else if (clr_done) begin
                    fsm_d = AC_IDLE;
                end
            end
            AC_EMERG: begin
                if (ack_rise) begin
                    fsm_d      = AC_SIL;
                    sil_from_d = AC_EMERG;
                end else if (clr_done) begin
                    fsm_d = (state == STATE_ATTENTION) ? AC_ATTN : AC_IDLE;
                end
            end
            AC_SIL: begin
                if ((sil_from_q == AC_ATTN) && (state == STATE_EMERGENCY)) begin
                    fsm_d = AC_EMERG;
                end else if (sil_done) begin
                    if (state == STATE_EMERGENCY)      fsm_d = AC_EMERG;
                    else if (state == STATE_ATTENTION) fsm_d = AC_ATTN;
                    else                               fsm_d = AC_IDLE;
                end
            end
            default: fsm_d = AC_IDLE;
        endcase

        // Clear counter: restarts on any non-qualifying cycle or state change
        clr_cyc_d = clr_cyc_q;
        clr_sec_d = clr_sec_q;
        if (!clr_cond || (fsm_d != fsm_q)) begin
            clr_cyc_d = '0;
            clr_sec_d = '0;
        end else if (clr_cyc_q == C_SEC_LAST) begin
            clr_cyc_d = '0;
            if (clr_sec_q != C_CLR_LAST) clr_sec_d = clr_sec_q + CNT_W'(1);
        end else begin
            clr_cyc_d = clr_cyc_q + CNT_W'(1);
        end

        // Silence timer is zero on the entry cycle and saturates at its end
        sil_cnt_d = sil_cnt_q;
        if (fsm_q != AC_SIL)           sil_cnt_d = '0;
        else if (!sil_done)            sil_cnt_d = sil_cnt_q + CNT_W'(1);
    end

    // Phase restarts on each entry so the first displayed cycle is lit
    assign slow_restart = (fsm_d == AC_ATTN)  && (fsm_q != AC_ATTN);
    assign fast_restart = (fsm_d == AC_EMERG) && (fsm_q != AC_EMERG);

    blink_gen #(.HALF(SLOW_HALF)) u_slow (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (slow_restart),
        .phase   (slow_phase)
    );

    blink_gen #(.HALF(FAST_HALF)) u_fast (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (fast_restart),
        .phase   (fast_phase)
    );

    // ------------------------------------------------------------------
    // Output decode (registered from the current FSM state)
    // ------------------------------------------------------------------
    always_comb begin
        alarm_level_d = LEVEL_NONE;
        silenced_d    = 1'b0;
        leds_d        = '0;
        case (fsm_q)
            AC_ATTN: begin
                alarm_level_d = LEVEL_ATTN;
                leds_d        = {LED_W{slow_phase}};
            end
            AC_EMERG: begin
                alarm_level_d = LEVEL_EMERG;
                for (int i = 0; i < LED_W; i++) begin
                    leds_d[i] = ((i % 2) == 0) ? fast_phase : ~fast_phase;
                end
            end
            AC_SIL: begin
                alarm_level_d = (sil_from_q == AC_EMERG) ? LEVEL_EMERG : LEVEL_ATTN;
                silenced_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q         <= AC_IDLE;
            sil_from_q    <= AC_IDLE;
            ack_q         <= 1'b0;
            clr_cyc_q     <= '0;
            clr_sec_q     <= '0;
            sil_cnt_q     <= '0;
            alarm_level_q <= LEVEL_NONE;
            silenced_q    <= 1'b0;
            leds_q        <= '0;
        end else begin
            fsm_q         <= fsm_d;
            sil_from_q    <= sil_from_d;
            ack_q         <= ack;
            clr_cyc_q     <= clr_cyc_d;
            clr_sec_q     <= clr_sec_d;
            sil_cnt_q     <= sil_cnt_d;
            alarm_level_q <= alarm_level_d;
            silenced_q    <= silenced_d;
            leds_q        <= leds_d;
        end
    end

    assign alarm_level = alarm_level_q;
    assign silenced    = silenced_q;
    assign leds        = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_ctrl
// Description : Directed self-checking bench for alarm_ctrl with short
//               timing parameters (1 s = 10 cycles, silence 3 s, clear 2 s).
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ctrl;

    localparam int LED_W = 10;

    logic             clk;
    logic             rst_n;
    logic [1:0]       state;
    logic             ack;
    logic [1:0]       alarm_level;
    logic             silenced;
    logic [LED_W-1:0] leds;

    int checks = 0;
    int errors = 0;

    localparam logic [LED_W-1:0] C_ALL  = 10'h3FF;
    localparam logic [LED_W-1:0] C_EVEN = 10'b0101010101;
    localparam logic [LED_W-1:0] C_ODD  = 10'b1010101010;

    alarm_ctrl #(
        .LED_W       (LED_W),
        .SEC_CYCLES  (10),
        .SLOW_HALF   (4),
        .FAST_HALF   (1),
        .SILENCE_SEC (3),
        .CLEAR_SEC   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .state       (state),
        .ack         (ack),
        .alarm_level (alarm_level),
        .silenced    (silenced),
        .leds        (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        state = 2'd3;
        ack   = 1'b0;
        #1 rst_n = 1'b0;

        // 1. reset with emergency present, then release
        step(3);
        chk("rst_level", 32'(alarm_level), 32'd0);
        chk("rst_sil",   32'(silenced),    32'd0);
        chk("rst_leds",  32'(leds),        32'd0);
        rst_n = 1'b1;
        step(1);
        chk("t1_lag", 32'(alarm_level), 32'd0);
        step(1);
        chk("t1_level", 32'(alarm_level), 32'd3);
        chk("t1_leds0", 32'(leds), 32'(C_EVEN));
        step(1);
        chk("t1_leds1", 32'(leds), 32'(C_ODD));
        step(1);
        chk("t1_leds2", 32'(leds), 32'(C_EVEN));

        // asynchronous reset mid-alarm
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(alarm_level), 32'd0);
        chk("arst_leds",  32'(leds),        32'd0);
        state = 2'd0;
        step(2);
        rst_n = 1'b1;
        step(2);
        chk("idle_level", 32'(alarm_level), 32'd0);

        // 2. attention for 5 cycles, then normal -> clear after 2 s
        state = 2'd2;
        step(1);
        chk("t2_lag", 32'(alarm_level), 32'd0);
        step(1);
        chk("t2_level", 32'(alarm_level), 32'd2);
        chk("t2_leds_on", 32'(leds), 32'(C_ALL));
        step(3);
        chk("t2_leds_on4", 32'(leds), 32'(C_ALL));
        state = 2'd0;
        step(1);
        chk("t2_leds_off", 32'(leds), 32'd0);
        step(19);
        chk("t2_hold", 32'(alarm_level), 32'd2);
        step(1);
        chk("t2_clear", 32'(alarm_level), 32'd0);

        // 3. interrupted clear restarts the count
        state = 2'd2;
        step(2);
        chk("t3_level", 32'(alarm_level), 32'd2);
        state = 2'd1;
        step(15);
        chk("t3_mid", 32'(alarm_level), 32'd2);
        state = 2'd2;
        step(1);
        state = 2'd1;
        step(20);
        chk("t3_restart", 32'(alarm_level), 32'd2);
        step(1);
        chk("t3_clear", 32'(alarm_level), 32'd0);

        // 4. emergency silenced for 30 cycles, resumes as attention
        state = 2'd3;
        step(2);
        chk("t4_level", 32'(alarm_level), 32'd3);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("t4_lag", 32'(silenced), 32'd0);
        step(1);
        chk("t4_sil", 32'(silenced), 32'd1);
        chk("t4_sil_leds", 32'(leds), 32'd0);
        chk("t4_sil_level", 32'(alarm_level), 32'd3);
        state = 2'd2;
        step(29);
        chk("t4_sil_end", 32'(silenced), 32'd1);
        chk("t4_sil_end_lvl", 32'(alarm_level), 32'd3);
        step(1);
        chk("t4_resume_sil", 32'(silenced), 32'd0);
        chk("t4_resume_lvl", 32'(alarm_level), 32'd2);
        chk("t4_resume_leds", 32'(leds), 32'(C_ALL));

        // 5. silenced attention escalates to emergency
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(1);
        chk("t5_sil", 32'(silenced), 32'd1);
        chk("t5_sil_lvl", 32'(alarm_level), 32'd2);
        step(3);
        state = 2'd3;
        step(1);
        chk("t5_lag", 32'(silenced), 32'd1);
        step(1);
        chk("t5_unsil", 32'(silenced), 32'd0);
        chk("t5_level", 32'(alarm_level), 32'd3);
        chk("t5_leds", 32'(leds), 32'(C_EVEN));

        // emergency de-escalates to attention after 2 s at state 2
        state = 2'd2;
        step(20);
        chk("e2a_hold", 32'(alarm_level), 32'd3);
        step(1);
        chk("e2a_level", 32'(alarm_level), 32'd2);

        // 6. escalation and ack edge in the same cycle
        state = 2'd3;
        ack   = 1'b1;
        step(2);
        chk("t6_level", 32'(alarm_level), 32'd3);
        chk("t6_sil", 32'(silenced), 32'd0);
        step(5);
        chk("t6_sil_held", 32'(silenced), 32'd0);
        ack   = 1'b0;
        state = 2'd0;
        step(21);
        chk("t6_idle", 32'(alarm_level), 32'd0);

        // ack held high in idle has no effect
        ack = 1'b1;
        step(50);
        chk("t6_ack_lvl", 32'(alarm_level), 32'd0);
        chk("t6_ack_sil", 32'(silenced), 32'd0);
        chk("t6_ack_leds", 32'(leds), 32'd0);
        state = 2'd2;
        step(2);
        chk("t6_attn_lvl", 32'(alarm_level), 32'd2);
        chk("t6_attn_sil", 32'(silenced), 32'd0);
        ack = 1'b0;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
